// File: rtl/dap_bit_sequencer.sv
// Bit-level shifter for a debug access port: drives and samples one data line on baud strobes.
// Define DAP_SEQ_PARITY_EN to add a running XOR of the sampled bits on rsp_parity.
module dap_bit_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(DATA_WIDTH)-1:0] cmd_len,
    input  logic                          cmd_dir,
    input  logic [DATA_WIDTH-1:0]         cmd_wdata,
    input  logic                          abort,
    input  logic                          sclk_pulse,
    input  logic                          sclk_delay_pulse,
    input  logic                          io_in,
    output logic                          io_out,
    output logic                          io_oe,
    output logic                          baud_en,
    output logic                          busy,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_parity
);
    localparam int unsigned LW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StArm, StShift, StResp} state_e;

    state_e                state_q, state_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic [LW:0]           tx_idx_q, tx_idx_d;
    logic                  dir_q, dir_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  io_out_q, io_out_d;
    logic                  io_oe_q, io_oe_d;
`ifdef DAP_SEQ_PARITY_EN
    logic                  par_q, par_d;
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        tx_idx_d = tx_idx_q;
        dir_d    = dir_q;
        wdata_d  = wdata_q;
        rx_d     = rx_q;
        io_out_d = io_out_q;
        io_oe_d  = io_oe_q;
`ifdef DAP_SEQ_PARITY_EN
        par_d    = par_q;
`endif
        if (abort) begin
            state_d = StIdle;
            io_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        len_d    = cmd_len;
                        dir_d    = cmd_dir;
                        wdata_d  = cmd_wdata;
                        rx_d     = '0;
                        cnt_d    = '0;
                        tx_idx_d = '0;
`ifdef DAP_SEQ_PARITY_EN
                        par_d    = 1'b0;
`endif
                        state_d  = StArm;
                    end
                end
                // Sample strobes are ignored here: the line has not been set up yet.
                StArm: begin
                    if (sclk_pulse) begin
                        state_d  = StShift;
                        tx_idx_d = (LW+1)'(1);
                        if (dir_q) begin
                            io_out_d = wdata_q[0];
                            io_oe_d  = 1'b1;
                        end
                    end
                end
                StShift: begin
                    if (sclk_pulse && dir_q && (tx_idx_q <= {1'b0, len_q})) begin
                        io_out_d = wdata_q[tx_idx_q[LW-1:0]];
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                    if (sclk_delay_pulse) begin
                        rx_d[cnt_q] = io_in;
`ifdef DAP_SEQ_PARITY_EN
                        par_d       = par_q ^ io_in;
`endif
                        // Counter parks on the final index instead of wrapping.
                        if (cnt_q == len_q) begin
                            state_d = StResp;
                            io_oe_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StResp: begin
                    if (rsp_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            len_q    <= '0;
            cnt_q    <= '0;
            tx_idx_q <= '0;
            dir_q    <= 1'b0;
            wdata_q  <= '0;
            rx_q     <= '0;
            io_out_q <= 1'b0;
            io_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            tx_idx_q <= tx_idx_d;
            dir_q    <= dir_d;
            wdata_q  <= wdata_d;
            rx_q     <= rx_d;
            io_out_q <= io_out_d;
            io_oe_q  <= io_oe_d;
        end
    end

`ifdef DAP_SEQ_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) par_q <= 1'b0;
        else         par_q <= par_d;
    end
    assign rsp_parity = par_q;
`else
    assign rsp_parity = 1'b0;
`endif

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign baud_en   = (state_q == StArm) || (state_q == StShift);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rx_q;
    assign io_out    = io_out_q;
    assign io_oe     = io_oe_q;

endmodule

// File: tb/tb_dap_bit_sequencer.sv
// Directed self-checking bench for dap_bit_sequencer (DATA_WIDTH = 32).
module tb_dap_bit_sequencer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_dir;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        abort, sclk_pulse, sclk_delay_pulse, io_in;
    logic        io_out, io_oe, baud_en, busy, rsp_valid, rsp_ready, rsp_parity;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dap_bit_sequencer #(.DATA_WIDTH(32)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_len          (cmd_len),
        .cmd_dir          (cmd_dir),
        .cmd_wdata        (cmd_wdata),
        .abort            (abort),
        .sclk_pulse       (sclk_pulse),
        .sclk_delay_pulse (sclk_delay_pulse),
        .io_in            (io_in),
        .io_out           (io_out),
        .io_oe            (io_oe),
        .baud_en          (baud_en),
        .busy             (busy),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_parity       (rsp_parity)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic exp_par(input logic [31:0] d);
`ifdef DAP_SEQ_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [4:0] len, input logic dir, input logic [31:0] wd);
        check_eq("cmd_ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        cmd_len = len; cmd_dir = dir; cmd_wdata = wd; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // One set-point strobe, then a sample strobe dly cycles later (0 = same cycle).
    task automatic do_bit(input int dly, input logic in_bit, input logic ab,
                          output logic drv, output logic oe);
        sclk_pulse = 1'b1;
        if (dly == 0) begin
            sclk_delay_pulse = 1'b1; io_in = in_bit; abort = ab;
        end
        step();
        sclk_pulse = 1'b0; sclk_delay_pulse = 1'b0; abort = 1'b0;
        drv = io_out; oe = io_oe;
        if (dly > 0) begin
            repeat (dly - 1) step();
            sclk_delay_pulse = 1'b1; io_in = in_bit; abort = ab;
            step();
            sclk_delay_pulse = 1'b0; abort = 1'b0;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        check_eq("rsp_valid_at_handshake", {31'b0, rsp_valid}, 32'd1);
        check_eq("cmd_ready_at_handshake", {31'b0, cmd_ready}, 32'd0);
        step();
        rsp_ready = 1'b0;
        check_eq("cmd_ready_after_handshake", {31'b0, cmd_ready}, 32'd1);
        check_eq("rsp_valid_after_handshake", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic        drv, oe, oe_all, oe_any;
        logic [7:0]  seq_a5;
        logic [31:0] wd, pat;
        logic [4:0]  bits4;

        resetn = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_dir = 1'b0; cmd_wdata = '0;
        abort = 1'b0; sclk_pulse = 1'b0; sclk_delay_pulse = 1'b0; io_in = 1'b0;
        rsp_ready = 1'b0;
        #2;
        check_eq("reset_busy", {31'b0, busy}, 32'd0);
        check_eq("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("reset_rdata", rsp_rdata, 32'd0);
        check_eq("reset_io", {29'b0, io_out, io_oe, baud_en}, 32'd0);
        step(); step();
        resetn = 1'b1;
        step();

        // Strobes while idle do nothing.
        sclk_pulse = 1'b1; sclk_delay_pulse = 1'b1; io_in = 1'b1;
        step();
        sclk_pulse = 1'b0; sclk_delay_pulse = 1'b0;
        check_eq("idle_pulse_busy", {30'b0, busy, baud_en}, 32'd0);

        // 8-bit drive of 0xA5, sample two cycles after the set point, data looped back.
        wd = 32'hA5; seq_a5 = 8'b1010_0101; oe_all = 1'b1;
        send_cmd(5'd7, 1'b1, wd);
        check_eq("arm_baud_busy", {30'b0, baud_en, busy}, 32'd3);
        check_eq("arm_io_oe", {31'b0, io_oe}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check_eq("t1_no_rsp_early", {31'b0, rsp_valid}, 32'd0);
            do_bit(2, wd[k], 1'b0, drv, oe);
            check_eq($sformatf("t1_io_out_bit%0d", k), {31'b0, drv}, {31'b0, seq_a5[k]});
            oe_all &= oe;
        end
        check_eq("t1_io_oe_during_shift", {31'b0, oe_all}, 32'd1);
        check_eq("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("t1_io_oe_resp", {31'b0, io_oe}, 32'd0);
        check_eq("t1_io_out_hold", {31'b0, io_out}, 32'd1);
        check_eq("t1_baud_en_resp", {31'b0, baud_en}, 32'd0);
        check_eq("t1_rdata", rsp_rdata, 32'h0000_00A5);
        check_eq("t1_parity", {31'b0, rsp_parity}, {31'b0, exp_par(32'hA5)});
        handshake();

        // 32-bit sample-only of 0xDEADBEEF.
        pat = 32'hDEAD_BEEF; oe_any = 1'b0;
        send_cmd(5'd31, 1'b0, 32'hFFFF_FFFF);
        for (int k = 0; k < 32; k++) begin
            do_bit(1, pat[k], 1'b0, drv, oe);
            oe_any |= oe | io_oe;
        end
        check_eq("t2_io_oe_never", {31'b0, oe_any}, 32'd0);
        check_eq("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check_eq("t2_parity", {31'b0, rsp_parity}, 32'd0);
        handshake();

        // Coincident strobes, len=3, io_in=1: the ARM-cycle sample is dropped.
        send_cmd(5'd3, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) do_bit(0, 1'b1, 1'b0, drv, oe);
        check_eq("t3_not_done_after_4", {31'b0, rsp_valid}, 32'd0);
        do_bit(0, 1'b1, 1'b0, drv, oe);
        check_eq("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("t3_rdata", rsp_rdata, 32'h0000_000F);
        handshake();

        // len=4 samples 1,0,1,1,0 -> 0x0D (odd parity), then a long stall with stray strobes.
        bits4 = 5'b01101;
        send_cmd(5'd4, 1'b0, 32'd0);
        for (int k = 0; k < 5; k++) do_bit(1, bits4[k], 1'b0, drv, oe);
        check_eq("t4_rdata", rsp_rdata, 32'h0000_000D);
        check_eq("t4_parity", {31'b0, rsp_parity}, {31'b0, exp_par(32'h0D)});
        for (int i = 0; i < 10; i++) begin
            sclk_pulse = i[0]; sclk_delay_pulse = ~i[0]; io_in = 1'b1;
            step();
        end
        sclk_pulse = 1'b0; sclk_delay_pulse = 1'b0;
        check_eq("t4_rdata_stable", rsp_rdata, 32'h0000_000D);
        check_eq("t4_cmd_ready_stall", {31'b0, cmd_ready}, 32'd0);
        check_eq("t4_rsp_valid_stall", {31'b0, rsp_valid}, 32'd1);
        handshake();

        // Abort on the 3rd sample of a 16-bit command, then a normal command.
        wd = 32'h1234;
        send_cmd(5'd15, 1'b1, wd);
        for (int k = 0; k < 3; k++) do_bit(1, wd[k], (k == 2), drv, oe);
        check_eq("t5_abort_busy", {31'b0, busy}, 32'd0);
        check_eq("t5_abort_io_oe", {31'b0, io_oe}, 32'd0);
        check_eq("t5_abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        step(); step();
        check_eq("t5_abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        wd = 32'h6;
        send_cmd(5'd3, 1'b1, wd);
        for (int k = 0; k < 4; k++) do_bit(1, wd[k], 1'b0, drv, oe);
        check_eq("t5_next_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("t5_next_rdata", rsp_rdata, 32'h0000_0006);
        handshake();

        // Asynchronous reset in the middle of a shift.
        send_cmd(5'd7, 1'b1, 32'hFF);
        do_bit(1, 1'b1, 1'b0, drv, oe);
        do_bit(1, 1'b1, 1'b0, drv, oe);
        check_eq("t6_pre_reset_io", {30'b0, io_out, io_oe}, 32'd3);
        #3;
        resetn = 1'b0;
        #1;
        check_eq("t6_reset_io", {29'b0, io_out, io_oe, baud_en}, 32'd0);
        check_eq("t6_reset_busy_valid", {30'b0, busy, rsp_valid}, 32'd0);
        check_eq("t6_reset_rdata", rsp_rdata, 32'd0);
        check_eq("t6_reset_parity", {31'b0, rsp_parity}, 32'd0);
        check_eq("t6_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        step();
        resetn = 1'b1;
        step(); step();
        check_eq("t6_no_rsp_after_reset", {31'b0, rsp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
